// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO controller: derived widths and the per-cycle operation encoding.
package fifo_pkg;

    // Occupancy has to hold the value depth itself, so it needs one more bit than the address
    function automatic int cnt_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address counter used for both the write and the read pointer.
module fifo_ptr #(
    parameter int AddrBits = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    output logic [AddrBits-1:0] ptr_o
);

    // The counter wraps from depth-1 back to 0 through natural overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= ptr_o + AddrBits'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer and flag controller: gates pushes and pops, drives the storage addresses,
// and keeps occupancy along with the full/empty/almost flags registered beside it.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AddrBits      = 3,
    parameter int AlmostFullTh  = 6,
    parameter int AlmostEmptyTh = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_i,
    input  logic                rd_i,
    output logic                wr_en_o,
    output logic [AddrBits-1:0] w_addr_o,
    output logic [AddrBits-1:0] r_addr_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [AddrBits:0]   count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int CntW = cnt_width(AddrBits);
    localparam logic [CntW-1:0] Depth = CntW'(depth_of(AddrBits));
    localparam logic [CntW-1:0] AfTh  = CntW'(AlmostFullTh);
    localparam logic [CntW-1:0] AeTh  = CntW'(AlmostEmptyTh);

    logic            push_ok;
    logic            pop_ok;
    fifo_op_e        op;
    logic [CntW-1:0] count_next;

    // Acceptance is decided from the registered flags, so a full FIFO still takes a pop
    assign push_ok = wr_i & ~full_o;
    assign pop_ok  = rd_i & ~empty_o;
    assign wr_en_o = push_ok;

    always_comb begin
        op         = fifo_op_e'({pop_ok, push_ok});
        count_next = count_o;
        unique case (op)
            OP_PUSH: count_next = count_o + CntW'(1);
            OP_POP:  count_next = count_o - CntW'(1);
            OP_NONE: count_next = count_o;
            OP_BOTH: count_next = count_o;
        endcase
    end

    // Flags come from the next count, so they change on the same edge as count_o
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            count_o        <= count_next;
            full_o         <= (count_next == Depth);
            empty_o        <= (count_next == '0);
            almost_full_o  <= (count_next >= AfTh);
            almost_empty_o <= (count_next <= AeTh);
            overflow_o     <= wr_i & full_o;
            underflow_o    <= rd_i & empty_o;
        end
    end

    fifo_ptr #(.AddrBits(AddrBits)) u_wptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (push_ok),
        .ptr_o (w_addr_o)
    );

    fifo_ptr #(.AddrBits(AddrBits)) u_rptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (pop_ok),
        .ptr_o (r_addr_o)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a queue-based FIFO model predicts each cycle's outputs and a
// negedge monitor compares them, including the data read back from a bench-side storage array.
module tb_fifo_ctrl;

    localparam int Depth = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic       wr_en;
    logic [2:0] w_addr;
    logic [2:0] r_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] mem [Depth];

    typedef struct {
        logic       wr_en;
        logic [2:0] w_addr;
        logic [2:0] r_addr;
        logic [3:0] count;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic       pop_chk;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] model_q [$];
    int         push_total = 0;
    int         pop_total  = 0;
    logic       ovf_pend   = 1'b0;
    logic       unf_pend   = 1'b0;

    int errors = 0;
    int checks = 0;

    fifo_ctrl #(
        .AddrBits      (3),
        .AlmostFullTh  (6),
        .AlmostEmptyTh (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_i           (wr),
        .rd_i           (rd),
        .wr_en_o        (wr_en),
        .w_addr_o       (w_addr),
        .r_addr_o       (r_addr),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .count_o        (count),
        .overflow_o     (overflow),
        .underflow_o    (underflow)
    );

    always #5 clk = ~clk;

    // Storage array the controller sequences: synchronous write, asynchronous read
    always @(posedge clk) begin
        if (wr_en) mem[w_addr] <= wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests; record what the DUT should show this cycle, then advance the model
    task automatic applyStimulus(input logic w, input logic r, input logic rs);
        exp_t e;
        int   sz;
        logic push_ok;
        logic pop_ok;
        @(posedge clk);
        #1;
        wr    = w;
        rd    = r;
        rst   = rs;
        wdata = 8'($urandom);
        sz    = model_q.size();
        e.count   = 4'(sz);
        e.full    = (sz == Depth);
        e.empty   = (sz == 0);
        e.af      = (sz >= 6);
        e.ae      = (sz <= 2);
        e.w_addr  = 3'(push_total % Depth);
        e.r_addr  = 3'(pop_total % Depth);
        e.ovf     = ovf_pend;
        e.unf     = unf_pend;
        e.wr_en   = w && (sz != Depth);
        e.pop_chk = r && (sz != 0);
        e.data    = (sz != 0) ? model_q[0] : 8'h00;
        exp_q.push_back(e);
        if (rs) begin
            model_q.delete();
            push_total = 0;
            pop_total  = 0;
            ovf_pend   = 1'b0;
            unf_pend   = 1'b0;
        end else begin
            push_ok = w && (sz != Depth);
            pop_ok  = r && (sz != 0);
            if (pop_ok) begin
                void'(model_q.pop_front());
                pop_total++;
            end
            if (push_ok) begin
                model_q.push_back(wdata);
                push_total++;
            end
            ovf_pend = w && !push_ok;
            unf_pend = r && !pop_ok;
        end
    endtask

    // Monitor: every negedge with a pending expectation, compare the full output set
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("wr_en",        32'(wr_en),        32'(e.wr_en));
                checkOutput("w_addr",       32'(w_addr),       32'(e.w_addr));
                checkOutput("r_addr",       32'(r_addr),       32'(e.r_addr));
                checkOutput("count",        32'(count),        32'(e.count));
                checkOutput("full",         32'(full),         32'(e.full));
                checkOutput("empty",        32'(empty),        32'(e.empty));
                checkOutput("almost_full",  32'(almost_full),  32'(e.af));
                checkOutput("almost_empty", 32'(almost_empty), 32'(e.ae));
                checkOutput("overflow",     32'(overflow),     32'(e.ovf));
                checkOutput("underflow",    32'(underflow),    32'(e.unf));
                checkOutput("ptr_invariant", 32'((w_addr - r_addr) & 3'h7), 32'(count[2:0]));
                checkOutput("full_and_empty", 32'(full & empty), 32'(0));
                if (e.pop_chk) checkOutput("read_data", 32'(mem[r_addr]), 32'(e.data));
            end
        end
    end

    initial begin
        int mode;
        repeat (2) @(posedge clk);
        $display("[TB] reset and idle");
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] fill to full, push while full");
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] drain, pop while empty");
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] fill 4 then simultaneous push and pop");
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b1, 1'b1, 1'b0);

        $display("[TB] push and pop at full and at empty");
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (7) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] reset with count 5 and push active");
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            mode = (i / 100) % 3;
            case (mode)
                0:       applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
                1:       applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
                default: applyStimulus(1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
            endcase
        end
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
